// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with glitch filter, frame checks, timeout and show-ahead FIFO.
// Define PS2_BREAK_DECODE_EN to fold E0/F0 prefixes into ext/brk flags on each FIFO entry.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          kbdclk,
    input  logic                          dat,
    output logic [7:0]                    keycode,
    output logic                          key_break,
    output logic                          key_ext,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_BREAK_DECODE_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          kc_s1, kc_s2, d_s1, d_s2;
    logic          kc_f, kc_prev;
    logic [FW-1:0] flt;
    logic          fall;

    state_t        state;
    logic [7:0]    sh;
    logic [2:0]    bcnt;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          push_req;
    logic [EW-1:0] push_data;
`ifdef PS2_BREAK_DECODE_EN
    logic          pend_ext, pend_brk;
`endif

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd, wr;
    logic [CW-1:0] cnt;
    logic [EW-1:0] head;
    logic          pop, full, acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            {kc_s1, kc_s2, d_s1, d_s2} <= '1;
        end else begin
            {kc_s1, kc_s2} <= {kbdclk, kc_s1};
            {d_s1, d_s2}   <= {dat, d_s1};
        end
    end

    // filtered clock only follows a run of FILTER_LEN samples that disagree with it
    always_ff @(posedge clk) begin
        if (rst) begin
            kc_f    <= 1'b1;
            kc_prev <= 1'b1;
            flt     <= '0;
        end else begin
            kc_prev <= kc_f;
            if (kc_s2 == kc_f)
                flt <= '0;
            else if (flt == FW'(FILTER_LEN - 1)) begin
                kc_f <= kc_s2;
                flt  <= '0;
            end else
                flt <= flt + 1'b1;
        end
    end

    assign fall = kc_prev & ~kc_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sh         <= '0;
            bcnt       <= '0;
            par        <= 1'b0;
            tcnt       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            push_req   <= 1'b0;
            push_data  <= '0;
`ifdef PS2_BREAK_DECODE_EN
            pend_ext   <= 1'b0;
            pend_brk   <= 1'b0;
`endif
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            push_req   <= 1'b0;
            tcnt       <= (fall || state == IDLE) ? '0 : tcnt + 1'b1;
            if (fall) begin
                case (state)
                    IDLE: if (!d_s2) begin
                        state <= DATA;
                        bcnt  <= '0;
                    end
                    DATA: begin
                        sh    <= {d_s2, sh[7:1]};
                        bcnt  <= bcnt + 1'b1;
                        if (bcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= d_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        state      <= IDLE;
                        parity_err <= ~^{sh, par};
                        frame_err  <= ~d_s2;
                        if (^{sh, par} && d_s2) begin
`ifdef PS2_BREAK_DECODE_EN
                            if (sh == 8'hE0)
                                pend_ext <= 1'b1;
                            else if (sh == 8'hF0)
                                pend_brk <= 1'b1;
                            else begin
                                push_req  <= 1'b1;
                                push_data <= {pend_ext, pend_brk, sh};
                                pend_ext  <= 1'b0;
                                pend_brk  <= 1'b0;
                            end
`else
                            push_req  <= 1'b1;
                            push_data <= sh;
`endif
                        end
`ifdef PS2_BREAK_DECODE_EN
                        if (!d_s2) begin
                            pend_ext <= 1'b0;
                            pend_brk <= 1'b0;
                        end
`endif
                    end
                endcase
            end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                tcnt      <= '0;
`ifdef PS2_BREAK_DECODE_EN
                pend_ext  <= 1'b0;
                pend_brk  <= 1'b0;
`endif
            end
        end
    end

    assign pop  = valid & ready;
    assign full = (cnt == CW'(FIFO_DEPTH));
    assign acc  = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (acc) mem[wr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd       <= '0;
            wr       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_req & full & ~pop;
            if (acc) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            cnt <= cnt + CW'(acc) - CW'(pop);
        end
    end

    assign head    = mem[rd];
    assign valid   = (cnt != '0);
    assign count   = cnt;
    assign keycode = valid ? head[7:0] : 8'h00;
`ifdef PS2_BREAK_DECODE_EN
    assign key_break = valid & head[8];
    assign key_ext   = valid & head[9];
`else
    assign key_break = 1'b0;
    assign key_ext   = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frames against a frame-level queue model of the receiver FIFO.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
    localparam int FL    = 4;
    localparam int TO    = 300;
    localparam int H     = 10;

    logic       clk = 1'b0;
    logic       rst, kbdclk, dat, ready;
    logic [7:0] keycode;
    logic       key_break, key_ext, valid;
    logic [3:0] count;
    logic       parity_err, frame_err, overflow;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .kbdclk(kbdclk), .dat(dat), .keycode(keycode),
        .key_break(key_break), .key_ext(key_ext), .valid(valid), .ready(ready),
        .count(count), .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    logic [9:0] q[$];
    logic [9:0] hd;
    int  n_cmp = 0, n_bad = 0;
    int  got_p = 0, got_f = 0, got_o = 0, exp_p = 0, exp_f = 0, exp_o = 0;
    bit  chk_en = 0;
`ifdef PS2_BREAK_DECODE_EN
    bit  pe = 0, pb = 0;
`endif

    always @(negedge clk) if (!rst) begin
        if (parity_err) got_p++;
        if (frame_err)  got_f++;
        if (overflow)   got_o++;
    end

    always @(negedge clk) if (chk_en) begin
        hd = (q.size() != 0) ? q[0] : 10'd0;
        n_cmp++;
        if (valid !== (q.size() != 0) || count !== 4'(q.size()) || keycode !== hd[7:0] ||
            key_break !== hd[8] || key_ext !== hd[9]) begin
            n_bad++;
            $display("FAIL fifo_state t=%0t got valid=%b count=%0d keycode=%h brk=%b ext=%b want valid=%b count=%0d keycode=%h brk=%b ext=%b",
                     $time, valid, count, keycode, key_break, key_ext, q.size() != 0, q.size(), hd[7:0], hd[8], hd[9]);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_perr"}, got_p, exp_p);
        check({tag, "_ferr"}, got_f, exp_f);
        check({tag, "_ovf"},  got_o, exp_o);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ~^d;
    endfunction

    task automatic enq(input logic [9:0] e);
        if (q.size() == DEPTH) exp_o++;
        else q.push_back(e);
    endtask

    task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
        logic perr, ferr;
        perr = ~^{d, p};
        ferr = ~s;
        if (perr) exp_p++;
        if (ferr) exp_f++;
        if (!perr && !ferr) begin
`ifdef PS2_BREAK_DECODE_EN
            if (d == 8'hE0) pe = 1;
            else if (d == 8'hF0) pb = 1;
            else begin
                enq({pe, pb, d});
                pe = 0;
                pb = 0;
            end
`else
            enq({2'b00, d});
`endif
        end
`ifdef PS2_BREAK_DECODE_EN
        if (ferr) begin
            pe = 0;
            pb = 0;
        end
`endif
    endtask

    task automatic send_bit(input logic b);
        dat = b;
        kbdclk = 1'b1;
        repeat (H) @(negedge clk);
        kbdclk = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        chk_en = 0;
        send_bit(s);
        dat = 1'b1;
        kbdclk = 1'b1;
        repeat (H) @(negedge clk);
        model_frame(d, p, s);
        chk_en = 1;
    endtask

    task automatic good_frame(input logic [7:0] d);
        send_frame(d, good_par(d), 1'b1);
    endtask

    task automatic pop_one();
        @(negedge clk);
        check("pop_head", keycode, q[0][7:0]);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        void'(q.pop_front());
    endtask

    initial begin
        rst = 1'b1; kbdclk = 1'b1; dat = 1'b1; ready = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_keycode", keycode, 0);
        check("rst_pulses", {parity_err, frame_err, overflow}, 0);
        rst = 1'b0;
        chk_en = 1;
        repeat (5) @(negedge clk);

        send_frame(8'h1C, 1'b0, 1'b1);
        check("kc_1C", keycode, 8'h1C);
        check("cnt_1", count, 1);
        check_pulses("frame_1C");
        pop_one();
        @(negedge clk);
        check("cnt_after_pop", count, 0);

        send_frame(8'h1C, 1'b1, 1'b1);
        check("perr_single", got_p, 1);
        check("perr_count", count, 0);
        send_frame(8'h32, 1'b0, 1'b1);
        check("kc_32", keycode, 8'h32);
        pop_one();

        send_frame(8'h55, good_par(8'h55), 1'b0);
        check("stop_ferr", got_f, 1);
        send_frame(8'h55, ~good_par(8'h55), 1'b0);
        check("both_perr", got_p, 2);
        check("both_ferr", got_f, 2);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        kbdclk = 1'b1;
        repeat (TO - 20) @(negedge clk);
        check("timeout_early", got_f, 2);
        repeat (40) @(negedge clk);
        exp_f++;
        check("timeout_ferr", got_f, 3);
        good_frame(8'h1C);
        check("kc_after_to", keycode, 8'h1C);
        check_pulses("timeout");
        pop_one();

        for (int i = 1; i <= 9; i++) good_frame(8'(i));
        check("ovf_count", count, 8);
        check("ovf_pulse", got_o, 1);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_order", keycode, i);
            pop_one();
        end
        check_pulses("overflow");

        dat = 1'b0;
        kbdclk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        kbdclk = 1'b1;
        dat = 1'b1;
        repeat (20) @(negedge clk);
        check_pulses("glitch");
        good_frame(8'h1C);
        check("kc_after_glitch", keycode, 8'h1C);
        pop_one();

        good_frame(8'h5A);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        kbdclk = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
`ifdef PS2_BREAK_DECODE_EN
        pe = 0;
        pb = 0;
`endif
        @(negedge clk);
        check("rst_mid_count", count, 0);
        chk_en = 1;
        good_frame(8'h1C);
        check("kc_after_rst", keycode, 8'h1C);
        check_pulses("rst_mid");
        pop_one();

        good_frame(8'hF0);
        good_frame(8'h1C);
        good_frame(8'hE0);
        good_frame(8'hF0);
        good_frame(8'h74);
`ifdef PS2_BREAK_DECODE_EN
        check("brk_count", count, 2);
        check("brk_head", {key_ext, key_break, keycode}, 10'h11C);
`else
        check("raw_count", count, 5);
        check("raw_head", {key_ext, key_break, keycode}, 10'h0F0);
`endif
        while (q.size() != 0) pop_one();
        @(negedge clk);
        check_pulses("final");

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver running in the system clock domain. Synchronises and glitch-filters the raw kbdclk/dat lines and deframes 11-bit PS/2 frames with start, parity and stop checking plus an inter-bit timeout. Valid scan codes are buffered in a show-ahead FIFO with a valid/ready pop handshake. Sits between the keyboard pins and the keycode consumer logic.

Parameters:
FIFO_DEPTH, 8, scan-code entries buffered; power of 2, >= 2
FILTER_LEN, 4, consecutive equal samples required before the filtered kbdclk changes level
TIMEOUT_CYCLES, 20000, clk cycles with no kbdclk falling edge before a partial frame is aborted

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
kbdclk  in  1  raw PS/2 clock, asynchronous
dat  in  1  raw PS/2 data, asynchronous
keycode  out  8  scan code at FIFO head (show-ahead)
key_break  out  1  head entry is a break code (PS2_BREAK_DECODE_EN only, else 0)
key_ext  out  1  head entry has the E0 prefix (PS2_BREAK_DECODE_EN only, else 0)
valid  out  1  FIFO not empty
ready  in  1  consumer pops head when valid && ready
count  out  $clog2(FIFO_DEPTH)+1  entries held
parity_err  out  1  one-cycle pulse: frame failed odd parity
frame_err  out  1  one-cycle pulse: bad stop bit or timeout
overflow  out  1  one-cycle pulse: good frame dropped because FIFO full

Behaviour:
- Reset (synchronous, active-high): all outputs 0; FIFO empty; FSM IDLE; synchronisers and filtered kbdclk preset to 1; timeout counter 0. Reset mid-frame discards the partial frame with no error pulse.
- Input path: two-flop synchroniser on kbdclk and dat. The filtered kbdclk changes level only after FILTER_LEN consecutive identical synchronised samples. A falling edge of the filtered clock is a bit event; synchronised dat is sampled in the same cycle.
- FSM, driven by bit events:
  - IDLE: dat=0 -> DATA with bit count 0. dat=1 -> stay IDLE, no error.
  - DATA: shift dat in LSB first; after the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: evaluate the frame -> IDLE.
- Frame evaluation: parity is good when the 8 data bits plus the parity bit contain an odd number of ones. Bad parity -> parity_err. Stop bit 0 -> frame_err. Both faults -> both pulses. Any fault -> byte discarded.
- Push: a good frame is written to the FIFO on the cycle after the stop-bit event. valid and count update on the following edge, so keycode is visible 2 clk after the stop-bit event.
- Timeout: the counter clears on every bit event and in IDLE. In DATA, PARITY or STOP, reaching TIMEOUT_CYCLES -> frame_err pulse, partial byte discarded, -> IDLE.
- FIFO: circular buffer with wrap-around pointers.
  - valid = (count != 0); keycode, key_break and key_ext come combinationally from the head entry.
  - Pop on valid && ready. ready is ignored when empty.
  - Push while full without a pop -> entry dropped, overflow pulses, contents unchanged.
  - Push while full with a pop in the same cycle -> accepted, count stays FIFO_DEPTH.
  - Push while empty with ready=1 -> no pop, count becomes 1.

Optional Feature:
PS2_BREAK_DECODE_EN:
- Defined: FIFO entries are 10 bits {ext, brk, code}.
  - A received E0 sets a pending-ext flag; a received F0 sets a pending-brk flag. Neither prefix is pushed.
  - The next non-prefix byte is pushed with both flags attached, then the flags clear.
  - A frame error or reset clears the pending flags.
- Undefined: entries are 8-bit raw bytes, E0 and F0 are pushed like any other byte, and key_break/key_ext are tied 0.

Test Plan:
- Frame 0x1C: start 0, data bits 0,0,1,1,1,0,0,0, parity 0, stop 1 -> valid=1, keycode=0x1C, count=1, no error pulses; a pop with ready=1 gives count=0.
- Same frame with parity 1 -> single parity_err pulse, count stays 0. Then frame 0x32 with parity 0 -> keycode=0x32.
- Five bits of a frame, then kbdclk held high for TIMEOUT_CYCLES -> frame_err pulse, FSM back in IDLE. Then frame 0x1C -> received correctly.
- FIFO_DEPTH=8, ready=0, nine frames 0x01..0x09 -> count=8, overflow pulse on the 9th frame; popping returns 0x01..0x08 in order.
- kbdclk low glitch of FILTER_LEN-1 cycles in IDLE -> no state change, no pulses. Reset asserted mid-frame after 4 bits -> count=0, next frame 0x1C received correctly.
- F0 1C then E0 F0 74:
  - macro defined: two entries, {0x1C, brk=1, ext=0} and {0x74, brk=1, ext=1}.
  - macro undefined: five raw entries F0, 1C, E0, F0, 74.
